// File: rtl/aes_bridge_pkg.sv
// Shared types and constants for the AES register-file bridge.
package aes_bridge_pkg;

   typedef logic [127:0] block_t;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      ISSUE,
      WAIT,
      WRITEBACK
   } state_t;

   localparam logic [4:0] X28_ADDR = 5'd28;
   localparam logic [4:0] X31_ADDR = 5'd31;

   // Word 0 is x28 and sits in the most significant 32 bits of the block.
   function automatic logic [31:0] word_of(input block_t blk, input logic [1:0] idx);
      logic [31:0] w;
      case (idx)
         2'd0:    w = blk[127:96];
         2'd1:    w = blk[95:64];
         2'd2:    w = blk[63:32];
         default: w = blk[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/aes_bridge_wb_seq.sv
// Write-back word sequencer: walks x28..x31 through the register-file
// write-mux request/grant handshake, one word per granted cycle.
module aes_bridge_wb_seq
   import aes_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] start_word,
   input  block_t      result_block,
   input  logic        wb_gnt,
   output logic        wb_req,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        last
);

   logic [1:0] idx;
   logic [1:0] idx_inc;
   logic       beat;

   assign beat    = wb_req && wb_gnt;
   assign idx_inc = idx + 2'd1;
   assign last    = beat && (idx == 2'd3);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx     <= 2'd0;
         wb_req  <= 1'b0;
         wb_addr <= X28_ADDR;
         wb_data <= 32'd0;
      end else if (start) begin
         idx     <= 2'd0;
         wb_req  <= 1'b1;
         wb_addr <= X28_ADDR;
         wb_data <= start_word;
      end else if (beat) begin
         if (idx == 2'd3) begin
            idx     <= 2'd0;
            wb_req  <= 1'b0;
            wb_addr <= X28_ADDR;
            wb_data <= 32'd0;
         end else begin
            idx     <= idx_inc;
            wb_addr <= X28_ADDR + {3'b000, idx_inc};
            wb_data <= word_of(result_block, idx_inc);
         end
      end
   end

endmodule

// File: rtl/aes_reg_bridge.sv
// Bridges x28..x31 to the AES core and writes the result back.
// Optional WAIT watchdog enabled by defining AES_BRIDGE_TIMEOUT_EN.
module aes_reg_bridge
   import aes_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rf_we,
   input  logic [4:0]   rf_waddr,
   input  logic [31:0]  register_28,
   input  logic [31:0]  register_29,
   input  logic [31:0]  register_30,
   input  logic [31:0]  register_31,
   input  logic [127:0] key_i,
   output logic         aes_valid,
   input  logic         aes_ready,
   output logic [127:0] aes_data,
   output logic [127:0] aes_key,
   input  logic         aes_done,
   input  logic [127:0] aes_result,
   output logic         wb_req,
   input  logic         wb_gnt,
   output logic [4:0]   wb_addr,
   output logic [31:0]  wb_data,
   output logic         busy,
   output logic         done,
   output logic         overrun,
   output logic         timeout_err
);

   state_t state, state_nxt;
   block_t data_q, key_q, result_q;
   logic   x31_wr;
   logic   wb_start;
   logic   wb_last;
   logic   tmo_hit;
   logic   tmo_abort;

   assign x31_wr   = rf_we && (rf_waddr == X31_ADDR);
   assign aes_data = data_q;
   assign aes_key  = key_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: defaults first, so no path through this block can infer a latch.
   always_comb begin
      state_nxt = state;
      wb_start  = 1'b0;
      tmo_abort = 1'b0;
      case (state)
         IDLE:      if (x31_wr) state_nxt = CAPTURE;
         CAPTURE:   state_nxt = ISSUE;
         ISSUE:     if (aes_valid && aes_ready) state_nxt = WAIT;
         WAIT: begin
            if (aes_done) begin
               state_nxt = WRITEBACK;
               wb_start  = 1'b1;
            end else if (tmo_hit) begin
               state_nxt = IDLE;
               tmo_abort = 1'b1;
            end
         end
         WRITEBACK: if (wb_last) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // CAPTURE is one cycle late so the falling-edge tap update has landed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q    <= '0;
         key_q     <= '0;
         result_q  <= '0;
         aes_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (state == CAPTURE) begin
            data_q <= {register_28, register_29, register_30, register_31};
            key_q  <= key_i;
         end
         if (wb_start) result_q <= aes_result;
         aes_valid <= (state_nxt == ISSUE);
         busy      <= (state_nxt != IDLE);
         done      <= ((state == WRITEBACK) && wb_last) || tmo_abort;
         if (x31_wr && (state != IDLE)) overrun <= 1'b1;
      end
   end

`ifdef AES_BRIDGE_TIMEOUT_EN
   logic [CNT_W-1:0] wait_cnt;

   assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state != WAIT)  wait_cnt <= '0;
         else                wait_cnt <= wait_cnt + 1'b1;
         if (tmo_abort) timeout_err <= 1'b1;
      end
   end
`else
   logic [CNT_W-1:0] unused_tmo_cfg;

   assign unused_tmo_cfg = CNT_W'(TIMEOUT_CYCLES);
   assign tmo_hit        = 1'b0;
   assign timeout_err    = 1'b0;
`endif

   aes_bridge_wb_seq u_wb_seq (
      .clk          (clk),
      .reset        (reset),
      .start        (wb_start),
      .start_word   (word_of(aes_result, 2'd0)),
      .result_block (result_q),
      .wb_gnt       (wb_gnt),
      .wb_req       (wb_req),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .last         (wb_last)
   );

endmodule

// File: tb/tb_aes_reg_bridge.sv
// Scoreboard bench for aes_reg_bridge: directed stimulus pushes expectations,
// a negedge monitor pops them on AES handshakes, write-back beats and done.
module tb_aes_reg_bridge;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         rf_we;
   logic [4:0]   rf_waddr;
   logic [31:0]  register_28, register_29, register_30, register_31;
   logic [127:0] key_i;
   logic         aes_valid;
   logic         aes_ready;
   logic [127:0] aes_data;
   logic [127:0] aes_key;
   logic         aes_done;
   logic [127:0] aes_result;
   logic         wb_req;
   logic         wb_gnt;
   logic [4:0]   wb_addr;
   logic [31:0]  wb_data;
   logic         busy;
   logic         done;
   logic         overrun;
   logic         timeout_err;

   int checks = 0;
   int errors = 0;
   int done_pending = 0;
   logic [255:0] aes_q[$];
   wb_exp_t      wb_q[$];
   logic [255:0] aes_exp;
   wb_exp_t      wb_exp;

   localparam logic [127:0] PT1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] KEY1 = 128'h00010203_04050607_08090A0B_0C0D0E0F;
   localparam logic [127:0] CT1 = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
   localparam logic [127:0] PT2 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
   localparam logic [127:0] KEY2 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
   localparam logic [127:0] RES2 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
   localparam logic [127:0] PT3 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
   localparam logic [127:0] RES3 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;

   aes_reg_bridge #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .register_28 (register_28),
      .register_29 (register_29),
      .register_30 (register_30),
      .register_31 (register_31),
      .key_i       (key_i),
      .aes_valid   (aes_valid),
      .aes_ready   (aes_ready),
      .aes_data    (aes_data),
      .aes_key     (aes_key),
      .aes_done    (aes_done),
      .aes_result  (aes_result),
      .wb_req      (wb_req),
      .wb_gnt      (wb_gnt),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every DUT-presented event against the scoreboard.
   always @(negedge clk) begin
      if (aes_valid && aes_ready) begin
         if (aes_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL aes_issue: unexpected handshake data %h", aes_data);
         end else begin
            aes_exp = aes_q.pop_front();
            check("aes_data", aes_data, aes_exp[255:128]);
            check("aes_key", aes_key, aes_exp[127:0]);
         end
      end
      if (wb_req && wb_gnt) begin
         if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_beat: unexpected write addr %0d data %h", wb_addr, wb_data);
         end else begin
            wb_exp = wb_q.pop_front();
            check("wb_addr", {123'd0, wb_addr}, {123'd0, wb_exp.addr});
            check("wb_data", {96'd0, wb_data}, {96'd0, wb_exp.data});
         end
      end
      if (done) begin
         if (done_pending == 0) begin
            checks++; errors++;
            $display("FAIL done_pulse: unexpected done got 1 expected 0");
         end else begin
            done_pending--;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_aes_valid"}, {127'd0, aes_valid}, 128'd0);
      check({tag, "_aes_data"}, aes_data, 128'd0);
      check({tag, "_aes_key"}, aes_key, 128'd0);
      check({tag, "_wb_req"}, {127'd0, wb_req}, 128'd0);
      check({tag, "_wb_addr"}, {123'd0, wb_addr}, 128'd28);
      check({tag, "_wb_data"}, {96'd0, wb_data}, 128'd0);
      check({tag, "_busy"}, {127'd0, busy}, 128'd0);
      check({tag, "_done"}, {127'd0, done}, 128'd0);
      check({tag, "_overrun"}, {127'd0, overrun}, 128'd0);
      check({tag, "_timeout_err"}, {127'd0, timeout_err}, 128'd0);
   endtask

   // Loads the taps and writes x31; returns in cycle t+1.
   task automatic start_block(input logic [127:0] blk, input logic [127:0] k);
      register_28 = blk[127:96];
      register_29 = blk[95:64];
      register_30 = blk[63:32];
      register_31 = blk[31:0];
      key_i       = k;
      aes_q.push_back({blk, k});
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      tick();
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
   endtask

   // Pulses aes_done with res and expects the first n write-back beats; returns in d+1.
   task automatic finish_block(input logic [127:0] res, input int n);
      wb_exp_t e;
      for (int i = 0; i < n; i++) begin
         e.addr = 5'(28 + i);
         e.data = res[127 - 32*i -: 32];
         wb_q.push_back(e);
      end
      if (n == 4) done_pending++;
      aes_result = res;
      aes_done   = 1'b1;
      tick();
      aes_done   = 1'b0;
      aes_result = '0;
   endtask

   task automatic clean_round_trip(input string tag);
      start_block(PT1, KEY1);
      repeat (3) tick();
      finish_block(CT1, 4);
      repeat (4) tick();
      check({tag, "_done"}, {127'd0, done}, 128'd1);
      check({tag, "_busy_low"}, {127'd0, busy}, 128'd0);
      tick();
   endtask

   initial begin
      reset = 1'b0;
      rf_we = 1'b0;
      rf_waddr = 5'd0;
      register_28 = '0; register_29 = '0; register_30 = '0; register_31 = '0;
      key_i = '0;
      aes_ready = 1'b1;
      aes_done = 1'b0;
      aes_result = '0;
      wb_gnt = 1'b1;
      repeat (3) tick();
      check_reset_outputs("rst");
      reset = 1'b1;
      tick();

      // Writes to other registers, or x31 without rf_we, must not start.
      rf_we = 1'b1; rf_waddr = 5'd30;
      tick();
      rf_we = 1'b0; rf_waddr = 5'd31;
      tick();
      rf_waddr = 5'd0;
      check("no_start_busy", {127'd0, busy}, 128'd0);

      // Basic round trip with FIPS-197 vectors and latency checks.
      start_block(PT1, KEY1);
      check("t1_busy", {127'd0, busy}, 128'd1);
      check("t1_valid_low", {127'd0, aes_valid}, 128'd0);
      tick();
      check("t2_valid", {127'd0, aes_valid}, 128'd1);
      check("t2_data", aes_data, PT1);
      tick();
      check("t3_valid_low", {127'd0, aes_valid}, 128'd0);
      check("t3_busy", {127'd0, busy}, 128'd1);
      repeat (2) tick();
      finish_block(CT1, 4);
      check("d1_wb_req", {127'd0, wb_req}, 128'd1);
      check("d1_wb_addr", {123'd0, wb_addr}, 128'd28);
      check("d1_wb_data", {96'd0, wb_data}, 128'h69C4E0D8);
      repeat (3) tick();
      check("d4_wb_addr", {123'd0, wb_addr}, 128'd31);
      check("d4_wb_data", {96'd0, wb_data}, 128'h70B4C55A);
      check("d4_done_low", {127'd0, done}, 128'd0);
      tick();
      check("d5_done", {127'd0, done}, 128'd1);
      check("d5_busy_low", {127'd0, busy}, 128'd0);
      check("d5_wb_req_low", {127'd0, wb_req}, 128'd0);
      tick();
      check("d6_done_low", {127'd0, done}, 128'd0);

      // Issue backpressure, then a write-back grant stall on idx=1.
      aes_ready = 1'b0;
      start_block(PT2, KEY2);
      tick();
      repeat (5) begin
         check("bp_valid", {127'd0, aes_valid}, 128'd1);
         check("bp_data", aes_data, PT2);
         check("bp_key", aes_key, KEY2);
         tick();
      end
      aes_ready = 1'b1;
      tick();
      check("bp_wait_valid_low", {127'd0, aes_valid}, 128'd0);
      check("bp_wait_busy", {127'd0, busy}, 128'd1);
      finish_block(RES2, 4);
      tick();
      wb_gnt = 1'b0;
      repeat (3) begin
         check("stall_addr", {123'd0, wb_addr}, 128'd29);
         check("stall_data", {96'd0, wb_data}, 128'hCAFEF00D);
         check("stall_req", {127'd0, wb_req}, 128'd1);
         tick();
      end
      wb_gnt = 1'b1;
      repeat (3) tick();
      check("stall_done", {127'd0, done}, 128'd1);
      tick();

      // Overrun: x31 written during WAIT is flagged but not queued.
      start_block(PT3, KEY1);
      check("ovr_pre", {127'd0, overrun}, 128'd0);
      repeat (3) tick();
      register_28 = 32'hFFFFFFFF; register_31 = 32'h0;
      rf_we = 1'b1; rf_waddr = 5'd31;
      tick();
      rf_we = 1'b0; rf_waddr = 5'd0;
      check("ovr_set", {127'd0, overrun}, 128'd1);
      check("ovr_busy", {127'd0, busy}, 128'd1);
      check("ovr_valid_low", {127'd0, aes_valid}, 128'd0);
      tick();
      finish_block(RES3, 4);
      repeat (4) tick();
      check("ovr_done", {127'd0, done}, 128'd1);
      repeat (3) tick();
      check("ovr_idle_busy", {127'd0, busy}, 128'd0);
      check("ovr_idle_valid", {127'd0, aes_valid}, 128'd0);
      check("ovr_sticky", {127'd0, overrun}, 128'd1);

      // Reset while in WAIT abandons the block.
      start_block(PT2, KEY2);
      repeat (3) tick();
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_wait");
      tick();
      reset = 1'b1;
      tick();
      clean_round_trip("post_wait_rst");

      // Reset during WRITEBACK with idx=2.
      start_block(PT3, KEY2);
      repeat (3) tick();
      finish_block(RES2, 2);
      repeat (2) tick();
      check("wb2_addr", {123'd0, wb_addr}, 128'd30);
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_wb");
      tick();
      reset = 1'b1;
      tick();
      clean_round_trip("post_wb_rst");

`ifdef AES_BRIDGE_TIMEOUT_EN
      // Watchdog abort after 16 WAIT cycles with no aes_done.
      start_block(PT2, KEY1);
      done_pending++;
      repeat (2) tick();
      repeat (15) tick();
      check("tmo_not_yet", {127'd0, timeout_err}, 128'd0);
      check("tmo_busy", {127'd0, busy}, 128'd1);
      tick();
      check("tmo_err", {127'd0, timeout_err}, 128'd1);
      check("tmo_done", {127'd0, done}, 128'd1);
      check("tmo_busy_low", {127'd0, busy}, 128'd0);
      check("tmo_no_wb", {127'd0, wb_req}, 128'd0);
      tick();
      check("tmo_done_low", {127'd0, done}, 128'd0);
      check("tmo_sticky", {127'd0, timeout_err}, 128'd1);
`endif

      repeat (3) tick();
      check("aes_q_empty", 128'(aes_q.size()), 128'd0);
      check("wb_q_empty", 128'(wb_q.size()), 128'd0);
      check("done_pending", 128'(done_pending), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_reg_bridge.md
# aes_reg_bridge

Moves a 128-bit block between the RISC-V register file and the AES core. Snoops the register-file write port, latches x28–x31 when software writes x31, and issues the block to the AES core with a valid/ready handshake. When the AES core finishes, the result is written back into x28–x31 through an arbitrated register-file write request. It sits directly downstream of the register file's x28–x31 taps and upstream of the register file's write-port mux.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before abort (only with the timeout feature).
- CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rf_we  in  1  register-file write enable (snooped).
- rf_waddr  in  5  register-file write address (snooped).
- register_28 .. register_31  in  32 each  register-file taps, x28–x31.
- key_i  in  128  AES key; sampled together with the data block.
- aes_valid  out  1  block and key valid to the AES core.
- aes_ready  in  1  AES core accepts the block.
- aes_data  out  128  {x28, x29, x30, x31}; x28 occupies bits 127:96.
- aes_key  out  128  latched key.
- aes_done  in  1  one-cycle pulse from the AES core; result valid.
- aes_result  in  128  AES output, same word order as aes_data.
- wb_req  out  1  write-back request to the register-file write mux.
- wb_gnt  in  1  write-back grant; the CPU write has priority.
- wb_addr  out  5  28..31.
- wb_data  out  32  write-back word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the x31 write-back is granted.
- overrun  out  1  sticky; set when x31 is written while busy. Cleared only by reset.
- timeout_err  out  1  sticky; set on timeout abort (feature only).

## Operation
- FSM states: IDLE, CAPTURE, ISSUE, WAIT, WRITEBACK.
- IDLE -> CAPTURE when rf_we=1 and rf_waddr=31.
- CAPTURE takes one cycle. It lets the register-file taps settle (they update on the falling edge), then latches register_28..31 into a 128-bit data register and key_i into the key register. Goes to ISSUE.
- ISSUE: drive aes_valid=1. Go to WAIT on the cycle where aes_valid and aes_ready are both 1. aes_data and aes_key stay stable while aes_valid=1.
- WAIT: when aes_done=1, latch aes_result and go to WRITEBACK. A done pulse arriving in any other state is ignored.
- WRITEBACK: a 2-bit word index, idx, counts 0..3. Drive wb_req=1, wb_addr=28+idx, wb_data=result word idx. idx advances only on cycles where wb_req and wb_gnt are both 1. When idx=3 is granted, pulse done and return to IDLE.
- An x31 write seen in any state except IDLE is not queued; it only sets overrun.
- A reset assertion in any state returns the FSM to IDLE immediately and abandons the in-flight block.

## Timing
- Reset values: aes_valid=0, aes_data=0, aes_key=0, wb_req=0, wb_addr=28, wb_data=0, busy=0, done=0, overrun=0, timeout_err=0, idx=0, data and result registers 0.
- Latency with aes_ready=1 and wb_gnt always 1:
  - x31 write in cycle t.
  - CAPTURE in t+1.
  - aes_valid high in t+2.
  - WAIT from t+3.
  - aes_done arrives in cycle d; write-backs occur in d+1..d+4.
  - done pulses in d+5.
- busy rises in t+1 and falls together with the done pulse.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- AES_BRIDGE_TIMEOUT_EN defined:
  - WAIT counts cycles in a CNT_W-bit counter that is cleared on entry to WAIT.
  - If TIMEOUT_CYCLES elapse without aes_done, set timeout_err, skip write-back, pulse done, and return to IDLE.
- AES_BRIDGE_TIMEOUT_EN undefined:
  - No counter is built; WAIT waits indefinitely.
  - timeout_err is tied to 0.

## Structure
- Package aes_bridge_pkg holds:
  - the state enum type;
  - constants X28_ADDR=5'd28 and X31_ADDR=5'd31;
  - typedef block_t as logic [127:0].
- One sub-module, aes_bridge_wb_seq, contains the WRITEBACK word sequencer (idx counter, word select, wb_req/wb_gnt handshake). Everything else lives in aes_reg_bridge.

## Test plan
- Basic round trip:
  - Stimulus: load x28..x31 = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; key = 000102..0F; AES model returns the FIPS-197 ciphertext.
  - Response: aes_data = 00112233..CCDDEEFF in t+2; x28..x31 are written with 69C4E0D8, 6A7B0430, D8CDB780, 70B4C55A in order; one done pulse.
- Handshake backpressure: hold aes_ready=0 for 5 cycles -> aes_valid, aes_data and aes_key stay constant; WAIT is entered the cycle after ready rises.
- Grant stall: deassert wb_gnt for 3 cycles during idx=1 -> wb_addr holds 29 and wb_data holds; no word is skipped or duplicated.
- Overrun: write x31 while in WAIT -> overrun=1, the FSM is unaffected, and the original result is written back.
- Reset mid-operation: assert reset in WAIT and in WRITEBACK with idx=2 -> all outputs take their reset values immediately; a new x31 write starts a clean sequence.
- Timeout (AES_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16): no aes_done -> timeout_err=1 after 16 WAIT cycles, done pulses, and wb_req never asserts.
